// File: rtl/rx_module.sv
// UART receiver: 16x-oversampled deserialiser with runtime data/stop/parity
// configuration, one-cycle valid strobe and parity/framing error flags.
module rx_module (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_en_i,
    input  logic       baud_tick_i,
    input  logic [4:0] rx_conf_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    typedef struct packed {
        logic [1:0] data_size;
        logic [1:0] stop_size;
        logic       parity_en;
    } rx_conf_t;

    typedef enum logic [2:0] {
        IDLE,
        START_CHECK,
        RECV_DATA,
        RECV_PARITY,
        RECV_STOP,
        DONE
    } state_e;

    state_e     state_q;
    rx_conf_t   conf_q;
    logic       rx_meta_q;
    logic       rx_s_q;
    logic [3:0] tick_cnt_q;
    logic [3:0] tick_cnt_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] last_bit;
    logic       stop_second_q;
    logic [7:0] shift_q;
    logic       perr_q;
    logic       ferr_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       parity_err_q;
    logic       frame_err_q;
    logic       mid_bit;

    assign tick_cnt_d = tick_cnt_q + 4'd1;
    // The 16th tick of each bit period lands in the middle of the next bit.
    assign mid_bit    = baud_tick_i && (tick_cnt_q == 4'd15);
    // data_size + 4 is simply data_size with bit 2 set.
    assign last_bit   = {1'b1, conf_q.data_size};

    // Idle-high reset value keeps reset release from looking like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // giving two real stages instead of one collapsed stage.
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            conf_q        <= '0;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            stop_second_q <= 1'b0;
            shift_q       <= '0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && !rx_en_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_en_i && !rx_s_q) begin
                            tick_cnt_q <= '0;
                            conf_q     <= rx_conf_i;
                            shift_q    <= '0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            state_q    <= START_CHECK;
                        end
                    end
                    START_CHECK: begin
                        if (baud_tick_i) begin
                            if (tick_cnt_q == 4'd7) begin
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                                state_q    <= rx_s_q ? IDLE : RECV_DATA;
                            end else begin
                                tick_cnt_q <= tick_cnt_d;
                            end
                        end
                    end
                    RECV_DATA: begin
                        if (baud_tick_i) tick_cnt_q <= tick_cnt_d;
                        if (mid_bit) begin
                            shift_q[bit_cnt_q] <= rx_s_q;
                            if (bit_cnt_q == last_bit) begin
                                stop_second_q <= 1'b0;
                                state_q       <= conf_q.parity_en ? RECV_PARITY : RECV_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    RECV_PARITY: begin
                        if (baud_tick_i) tick_cnt_q <= tick_cnt_d;
                        if (mid_bit) begin
                            perr_q  <= ^{shift_q, rx_s_q};
                            state_q <= RECV_STOP;
                        end
                    end
                    RECV_STOP: begin
                        if (baud_tick_i) tick_cnt_q <= tick_cnt_d;
                        if (mid_bit) begin
                            if (!rx_s_q) ferr_q <= 1'b1;
                            if (conf_q.stop_size != 2'b00 && !stop_second_q) begin
                                stop_second_q <= 1'b1;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        rx_data_q    <= shift_q;
                        rx_valid_q   <= 1'b1;
                        parity_err_q <= perr_q;
                        frame_err_q  <= ferr_q;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign rx_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rx_module.sv
// Self-checking bench for rx_module: table-driven frames, randomized frames
// against a frame-level model, and hand-written glitch/back-to-back/abort cases.
module tb_rx_module;

    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;

    logic       clk_i;
    logic       rst_i;
    logic       rx_en_i;
    logic       baud_tick_i;
    logic [4:0] rx_conf_i;
    logic       uart_rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       rx_busy_o;

    rx_module dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_en_i     (rx_en_i),
        .baud_tick_i (baud_tick_i),
        .rx_conf_i   (rx_conf_i),
        .uart_rx_i   (uart_rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .rx_busy_o   (rx_busy_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rx_rec_t;

    typedef struct {
        logic [4:0] conf;
        logic [7:0] data;
        logic       par_bit;
        logic [1:0] stop_lv;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    rx_rec_t got_q[$];
    int      n_checks    = 0;
    int      n_fail      = 0;
    int      multi_valid = 0;
    logic    prev_valid  = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        baud_tick_i = 1'b0;
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk_i);
            baud_tick_i = 1'b1;
            @(negedge clk_i);
            baud_tick_i = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            got_q.push_back('{rx_data_o, parity_err_o, frame_err_o});
            if (prev_valid) multi_valid++;
        end
        prev_valid = rx_valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx_i = v;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [4:0] conf, input logic [7:0] data,
                              input logic par_bit, input logic [1:0] stop_lv);
        int n;
        n = int'(conf[4:3]) + 5;
        rx_conf_i = conf;
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(data[i]);
        if (conf[0]) drive_bit(par_bit);
        drive_bit(stop_lv[0]);
        if (conf[2:1] != 2'b00) drive_bit(stop_lv[1]);
        uart_rx_i = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d,
                                input logic pe, input logic fe);
        rx_rec_t rec;
        check({name, " valid_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            rec = got_q.pop_front();
            check({name, " data"}, rec.d, d);
            check({name, " parity_err"}, rec.pe, pe);
            check({name, " frame_err"}, rec.fe, fe);
        end
        got_q.delete();
    endtask

    // A frame with a low stop bit can legally retrigger start detection, so
    // allow a full frame time to drain before checking the receiver is idle.
    task automatic run_frame(input string name, input logic [4:0] conf, input logic [7:0] data,
                             input logic par_bit, input logic [1:0] stop_lv,
                             input logic [7:0] exp_d, input logic exp_pe, input logic exp_fe);
        send_frame(conf, data, par_bit, stop_lv);
        idle(8);
        expect_frame(name, exp_d, exp_pe, exp_fe);
        idle(exp_fe ? 14 * BIT_CLKS : BIT_CLKS);
        check({name, " busy_after"}, rx_busy_o, 1'b0);
        if (exp_fe) got_q.delete();
    endtask

    vec_t vecs[9];

    initial begin
        rx_rec_t    rec;
        logic [4:0] conf;
        logic [7:0] data;
        logic [7:0] mask;
        logic       par_bit;
        logic [1:0] stop_lv;
        logic       exp_pe;
        logic       exp_fe;
        int         n;

        vecs[0] = '{5'b11000, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{5'b00011, 8'h13, 1'b1, 2'b11, 8'h13, 1'b0, 1'b0};
        vecs[2] = '{5'b00011, 8'h13, 1'b0, 2'b11, 8'h13, 1'b1, 1'b0};
        vecs[3] = '{5'b11000, 8'hC3, 1'b0, 2'b10, 8'hC3, 1'b0, 1'b1};
        vecs[4] = '{5'b10011, 8'h7F, 1'b1, 2'b11, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{5'b00000, 8'hFF, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0};
        vecs[6] = '{5'b11100, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1};
        vecs[7] = '{5'b11001, 8'h0F, 1'b1, 2'b11, 8'h0F, 1'b1, 1'b0};
        vecs[8] = '{5'b01000, 8'h2A, 1'b0, 2'b11, 8'h2A, 1'b0, 1'b0};

        rst_i     = 1'b1;
        rx_en_i   = 1'b1;
        rx_conf_i = 5'b11000;
        uart_rx_i = 1'b1;
        idle(3);
        check("reset rx_data", rx_data_o, 8'h00);
        check("reset rx_valid", rx_valid_o, 1'b0);
        check("reset parity_err", parity_err_o, 1'b0);
        check("reset frame_err", frame_err_o, 1'b0);
        check("reset rx_busy", rx_busy_o, 1'b0);
        rst_i = 1'b0;
        idle(BIT_CLKS);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].conf, vecs[i].data, vecs[i].par_bit,
                      vecs[i].stop_lv, vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
        end

        // Frame-level model: keep the low data_size+5 bits, compare the sent
        // parity bit with the even-parity bit, flag any low stop bit.
        for (int i = 0; i < 16; i++) begin
            conf    = 5'($urandom_range(0, 31));
            data    = 8'($urandom);
            par_bit = 1'($urandom_range(0, 1));
            stop_lv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            n       = int'(conf[4:3]) + 5;
            mask    = 8'((1 << n) - 1);
            exp_pe  = conf[0] && (par_bit != ^(data & mask));
            exp_fe  = !stop_lv[0] || ((conf[2:1] != 2'b00) && !stop_lv[1]);
            run_frame($sformatf("rand%0d", i), conf, data, par_bit, stop_lv,
                      data & mask, exp_pe, exp_fe);
        end

        rx_conf_i = 5'b11000;
        uart_rx_i = 1'b0;
        idle(5 * TICK_CLKS);
        uart_rx_i = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch valid_count", got_q.size(), 0);
        check("glitch busy", rx_busy_o, 1'b0);
        got_q.delete();
        run_frame("after_glitch", 5'b11000, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0);

        send_frame(5'b11000, 8'h00, 1'b0, 2'b11);
        send_frame(5'b11000, 8'hFF, 1'b0, 2'b11);
        idle(8);
        check("b2b valid_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            rec = got_q.pop_front();
            check("b2b first data", rec.d, 8'h00);
            rec = got_q.pop_front();
            check("b2b second data", rec.d, 8'hFF);
            check("b2b second flags", {rec.pe, rec.fe}, 2'b00);
        end
        got_q.delete();
        idle(BIT_CLKS);

        rx_conf_i = 5'b11000;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(data_bit(8'h5A, i));
        uart_rx_i = 1'b1;
        idle(BIT_CLKS / 2);
        check("pre_reset busy", rx_busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("midreset rx_data", rx_data_o, 8'h00);
        check("midreset busy", rx_busy_o, 1'b0);
        check("midreset valid", rx_valid_o, 1'b0);
        idle(3);
        rst_i = 1'b0;
        idle(2 * BIT_CLKS);
        check("midreset valid_count", got_q.size(), 0);
        got_q.delete();
        run_frame("after_reset", 5'b11000, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0);

        rx_conf_i = 5'b11000;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("abort busy_before", rx_busy_o, 1'b1);
        rx_en_i = 1'b0;
        @(negedge clk_i);
        check("abort busy_next", rx_busy_o, 1'b0);
        uart_rx_i = 1'b0;
        idle(BIT_CLKS);
        uart_rx_i = 1'b1;
        idle(2 * BIT_CLKS);
        rx_en_i = 1'b1;
        idle(2 * BIT_CLKS);
        check("abort valid_count", got_q.size(), 0);
        check("abort data_held", rx_data_o, 8'h5A);
        got_q.delete();
        run_frame("after_abort", 5'b11000, 8'h66, 1'b0, 2'b11, 8'h66, 1'b0, 1'b0);

        check("valid pulse width", multi_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic data_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule
